turf_fragment_mux: RTL and testbench

TURF_FRAGMENT_MUX -- requirements
Module: turf_fragment_mux

---
 rtl/turf_fragment_mux.sv | 235 +++++++++++++++++++++++
 tb/tb_turf_fragment_mux.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_fragment_mux.sv
// turf_fragment_mux
// Round-robin arbiter over NCHAN tagged input channels. Each granted transfer
// is cut into UDP fragments of at most nfragment_count_i+1 payload beats. Every
// fragment gets a header beat on m_hdr and a tag beat followed by payload on
// m_payload. If the destination path has never been opened, the granted
// transfer is drained and counted instead.
// Ports:
//   aclk, areset             clock, asynchronous active-high reset
//   nfragment_count_i        payload beats per fragment minus 1
//   fragsrc_mask_i           source-port bits taken from the fragment number
//   event_open_i/ip_i/port_i destination path open strobe, IP and port
//   s_ctrl_*                 per-channel control {addr[31:20], bytes[19:0]}
//   s_data_*                 per-channel payload stream
//   m_hdr_*                  UDP header {IP, port, UDP length}, tuser = src port
//   m_payload_*              UDP payload stream (tag beat, then data)
//   drop_count_o             saturating count of transfers drained while closed
module turf_fragment_mux #(
   parameter int unsigned NCHAN        = 2,
   parameter logic [15:0] BASE_PORT    = 16'h5430,
   parameter logic [15:0] TAG_CONSTANT = 16'hDA7A
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [9:0]          nfragment_count_i,
   input  logic [15:0]         fragsrc_mask_i,
   input  logic                event_open_i,
   input  logic [31:0]         event_ip_i,
   input  logic [15:0]         event_port_i,
   input  logic [NCHAN*32-1:0] s_ctrl_tdata,
   input  logic [NCHAN-1:0]    s_ctrl_tvalid,
   output logic [NCHAN-1:0]    s_ctrl_tready,
   input  logic [NCHAN*64-1:0] s_data_tdata,
   input  logic [NCHAN*8-1:0]  s_data_tkeep,
   input  logic [NCHAN-1:0]    s_data_tvalid,
   output logic [NCHAN-1:0]    s_data_tready,
   output logic [63:0]         m_hdr_tdata,
   output logic [15:0]         m_hdr_tuser,
   output logic                m_hdr_tvalid,
   input  logic                m_hdr_tready,
   output logic [63:0]         m_payload_tdata,
   output logic [7:0]          m_payload_tkeep,
   output logic                m_payload_tlast,
   output logic                m_payload_tvalid,
   input  logic                m_payload_tready,
   output logic [15:0]         drop_count_o
);

   typedef enum logic [2:0] {IDLE, HEADER, TAG, STREAM, DRAIN} state_t;

   state_t      state;
   logic [2:0]  ptr, grant, cand, idx;
   logic        found;
   logic [11:0] addr_q;
   logic [19:0] len_q, rem;
   logic [15:0] hdr_len;
   logic [9:0]  frag, beat, last_idx;
   logic        fin, open_q, ever_open;
   logic [31:0] ip_q;
   logic [15:0] port_q;
   logic [17:0] cur_beats;
   logic        cur_fin;
   logic [31:0] cand_ctrl;

   // Channels padded to 8 entries so a 3-bit channel index is always in range.
   logic [31:0] ctrl_arr [8];
   logic [63:0] data_arr [8];
   logic [7:0]  keep_arr [8];
   logic [7:0]  ctrl_valid8, data_valid8, ctrl_ready8, data_ready8;

   for (genvar g = 0; g < 8; g++) begin : g_pad
      if (g < NCHAN) begin : g_live
         assign ctrl_arr[g]    = s_ctrl_tdata[g*32 +: 32];
         assign data_arr[g]    = s_data_tdata[g*64 +: 64];
         assign keep_arr[g]    = s_data_tkeep[g*8 +: 8];
         assign ctrl_valid8[g] = s_ctrl_tvalid[g];
         assign data_valid8[g] = s_data_tvalid[g];
      end else begin : g_tie
         assign ctrl_arr[g]    = '0;
         assign data_arr[g]    = '0;
         assign keep_arr[g]    = '0;
         assign ctrl_valid8[g] = 1'b0;
         assign data_valid8[g] = 1'b0;
      end
   end

   function automatic logic [17:0] beats_of(input logic [19:0] bytes);
      return 18'(({1'b0, bytes} + 21'd7) >> 3);
   endfunction

   function automatic logic [15:0] udp_len_of(input logic [19:0] bytes, input logic [9:0] nfrag);
      if (beats_of(bytes) <= ({8'd0, nfrag} + 18'd1))
         return {3'd0, bytes[12:0]} + 16'd8;
      return {3'd0, nfrag, 3'd0} + 16'd16;
   endfunction

   // Round-robin search starting just above the last granted channel.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      idx   = '0;
      for (int unsigned i = 0; i < NCHAN; i++) begin
         idx = 3'((32'(ptr) + 32'd1 + i) % NCHAN);
         if (!found && ctrl_valid8[idx]) begin
            found = 1'b1;
            cand  = idx;
         end
      end
   end

   assign cand_ctrl = ctrl_arr[cand];
   assign cur_beats = beats_of(rem);
   assign cur_fin   = cur_beats <= ({8'd0, nfragment_count_i} + 18'd1);

   always_comb begin
      ctrl_ready8 = '0;
      data_ready8 = '0;
      if (state == IDLE && found && !areset)
         ctrl_ready8[cand] = 1'b1;
      if (state == STREAM)
         data_ready8[grant] = m_payload_tready;
      else if (state == DRAIN && rem != '0)
         data_ready8[grant] = 1'b1;
   end

   assign s_ctrl_tready = ctrl_ready8[NCHAN-1:0];
   assign s_data_tready = data_ready8[NCHAN-1:0];

   assign m_hdr_tvalid = (state == HEADER);
   assign m_hdr_tdata  = {ip_q, port_q, hdr_len};
   assign m_hdr_tuser  = (BASE_PORT & ~fragsrc_mask_i) | ({6'b0, frag} & fragsrc_mask_i);

   always_comb begin
      m_payload_tdata  = '0;
      m_payload_tkeep  = '0;
      m_payload_tlast  = 1'b0;
      m_payload_tvalid = 1'b0;
      case (state)
         TAG: begin
            m_payload_tdata  = {TAG_CONSTANT, grant, 3'b000, frag, addr_q, len_q};
            m_payload_tkeep  = 8'hFF;
            m_payload_tvalid = 1'b1;
            m_payload_tlast  = (len_q == '0);
         end
         STREAM: begin
            m_payload_tdata  = data_arr[grant];
            m_payload_tkeep  = keep_arr[grant];
            m_payload_tvalid = data_valid8[grant];
            m_payload_tlast  = fin && (beat == last_idx);
         end
         default: ;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state        <= IDLE;
         ptr          <= 3'(NCHAN - 1);
         grant        <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         rem          <= '0;
         hdr_len      <= '0;
         frag         <= '0;
         beat         <= '0;
         last_idx     <= '0;
         fin          <= 1'b0;
         open_q       <= 1'b0;
         ever_open    <= 1'b0;
         ip_q         <= '0;
         port_q       <= '0;
         drop_count_o <= '0;
      end else begin
         open_q <= event_open_i;
         if (event_open_i && !open_q) begin
            ip_q      <= event_ip_i;
            port_q    <= event_port_i;
            ever_open <= 1'b1;
         end
         case (state)
            IDLE: begin
               frag <= '0;
               if (found) begin
                  grant   <= cand;
                  ptr     <= cand;
                  addr_q  <= cand_ctrl[31:20];
                  len_q   <= cand_ctrl[19:0];
                  rem     <= cand_ctrl[19:0];
                  hdr_len <= udp_len_of(cand_ctrl[19:0], nfragment_count_i);
                  state   <= ever_open ? HEADER : DRAIN;
               end
            end
            HEADER: begin
               beat <= '0;
               if (m_hdr_tready) begin
                  // Final-fragment decision is taken from the bytes remaining
                  // before this fragment is subtracted.
                  rem      <= rem - {4'd0, hdr_len - 16'd8};
                  fin      <= cur_fin;
                  last_idx <= cur_fin ? 10'(cur_beats - 18'd1) : nfragment_count_i;
                  state    <= TAG;
               end
            end
            TAG: begin
               if (m_payload_tready) begin
                  frag    <= frag + 10'd1;
                  hdr_len <= udp_len_of(rem, nfragment_count_i);
                  state   <= (len_q == '0) ? IDLE : STREAM;
               end
            end
            STREAM: begin
               if (m_payload_tvalid && m_payload_tready) begin
                  if (fin && beat == last_idx)
                     state <= IDLE;
                  else if (beat == nfragment_count_i)
                     state <= HEADER;
                  else
                     beat <= beat + 10'd1;
               end
            end
            DRAIN: begin
               // rem counts bytes still to discard; a beat removes up to 8.
               if (rem == '0 || (data_valid8[grant] && rem <= 20'd8)) begin
                  state <= IDLE;
                  if (drop_count_o != 16'hFFFF)
                     drop_count_o <= drop_count_o + 16'd1;
               end else if (data_valid8[grant]) begin
                  rem <= rem - 20'd8;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_turf_fragment_mux.sv
// Directed self-checking bench for turf_fragment_mux (NCHAN=2).
module tb_turf_fragment_mux;
   localparam int unsigned NCH = 2;

   logic             aclk = 1'b0;
   logic             areset;
   logic [9:0]       nfragment_count_i;
   logic [15:0]      fragsrc_mask_i;
   logic             event_open_i;
   logic [31:0]      event_ip_i;
   logic [15:0]      event_port_i;
   logic [NCH*32-1:0] s_ctrl_tdata;
   logic [NCH-1:0]   s_ctrl_tvalid;
   logic [NCH-1:0]   s_ctrl_tready;
   logic [NCH*64-1:0] s_data_tdata;
   logic [NCH*8-1:0] s_data_tkeep;
   logic [NCH-1:0]   s_data_tvalid;
   logic [NCH-1:0]   s_data_tready;
   logic [63:0]      m_hdr_tdata;
   logic [15:0]      m_hdr_tuser;
   logic             m_hdr_tvalid;
   logic             m_hdr_tready;
   logic [63:0]      m_payload_tdata;
   logic [7:0]       m_payload_tkeep;
   logic             m_payload_tlast;
   logic             m_payload_tvalid;
   logic             m_payload_tready;
   logic [15:0]      drop_count_o;

   turf_fragment_mux #(
      .NCHAN(2),
      .BASE_PORT(16'h5430),
      .TAG_CONSTANT(16'hDA7A)
   ) dut (
      .aclk(aclk), .areset(areset),
      .nfragment_count_i(nfragment_count_i), .fragsrc_mask_i(fragsrc_mask_i),
      .event_open_i(event_open_i), .event_ip_i(event_ip_i), .event_port_i(event_port_i),
      .s_ctrl_tdata(s_ctrl_tdata), .s_ctrl_tvalid(s_ctrl_tvalid), .s_ctrl_tready(s_ctrl_tready),
      .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep),
      .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
      .m_hdr_tdata(m_hdr_tdata), .m_hdr_tuser(m_hdr_tuser),
      .m_hdr_tvalid(m_hdr_tvalid), .m_hdr_tready(m_hdr_tready),
      .m_payload_tdata(m_payload_tdata), .m_payload_tkeep(m_payload_tkeep),
      .m_payload_tlast(m_payload_tlast), .m_payload_tvalid(m_payload_tvalid),
      .m_payload_tready(m_payload_tready),
      .drop_count_o(drop_count_o)
   );

   always #5 aclk = ~aclk;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   int          dat_n, last_n, last_at, cyc, cur_ch;
   bit          want_tag, hold, bp, any_out;
   logic [15:0] hlen_q [$];
   logic [15:0] tuser_q [$];
   logic [47:0] hpath_q [$];
   logic [63:0] tag_q [$];
   int          grant_q [$];
   int          sent_k [NCH];
   int          rcv_k [NCH];
   int          consumed [NCH];

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int ch, input int k);
      return {16'hD0D0, 16'(ch), 32'(k) ^ 32'h5A5A_0000};
   endfunction

   function automatic logic [7:0] kp(input int ch);
      return (ch == 0) ? 8'hFF : 8'h3F;
   endfunction

   task automatic clear_logs();
      hlen_q.delete(); tuser_q.delete(); hpath_q.delete(); tag_q.delete(); grant_q.delete();
      dat_n = 0; last_n = 0; last_at = -1; any_out = 0; want_tag = 0;
      for (int c = 0; c < NCH; c++) begin
         sent_k[c] = 0; rcv_k[c] = 0; consumed[c] = 0;
         s_data_tdata[c*64 +: 64] = pat(c, 0);
      end
   endtask

   task automatic send(input int ch, input logic [11:0] addr, input logic [19:0] len);
      s_ctrl_tdata[ch*32 +: 32] = {addr, len};
      s_ctrl_tvalid[ch] = 1'b1;
   endtask

   // One clock: sample at negedge, update stimulus just after posedge.
   task automatic step();
      bit ct [NCH];
      bit dt [NCH];
      @(negedge aclk);
      for (int c = 0; c < NCH; c++) begin
         ct[c] = s_ctrl_tvalid[c] && s_ctrl_tready[c];
         dt[c] = s_data_tvalid[c] && s_data_tready[c];
         if (ct[c]) begin grant_q.push_back(c); cur_ch = c; end
         if (dt[c]) consumed[c]++;
      end
      if (m_hdr_tvalid || m_payload_tvalid) any_out = 1;
      if (m_hdr_tvalid && m_hdr_tready) begin
         hlen_q.push_back(m_hdr_tdata[15:0]);
         hpath_q.push_back(m_hdr_tdata[63:16]);
         tuser_q.push_back(m_hdr_tuser);
         want_tag = 1;
      end
      if (m_payload_tvalid && m_payload_tready) begin
         if (want_tag) begin
            tag_q.push_back(m_payload_tdata);
            check("tag_keep", 72'(m_payload_tkeep), 72'(8'hFF));
            want_tag = 0;
         end else begin
            check("payload", {m_payload_tkeep, m_payload_tdata}, {kp(cur_ch), pat(cur_ch, rcv_k[cur_ch])});
            rcv_k[cur_ch]++;
            dat_n++;
         end
         if (m_payload_tlast) begin last_n++; last_at = dat_n; end
      end
      @(posedge aclk); #1;
      cyc++;
      for (int c = 0; c < NCH; c++) begin
         if (ct[c] && !hold) s_ctrl_tvalid[c] = 1'b0;
         if (dt[c]) begin
            sent_k[c]++;
            s_data_tdata[c*64 +: 64] = pat(c, sent_k[c]);
         end
      end
      m_hdr_tready     = bp ? (cyc % 3 != 1) : 1'b1;
      m_payload_tready = bp ? (cyc % 4 != 2) : 1'b1;
   endtask

   task automatic run(input string tag, input int max_cyc, input int want_last, input int want_dat);
      int  n;
      bit  done;
      n = 0;
      done = 0;
      while (n < max_cyc && !done) begin
         step();
         n++;
         done = (want_last > 0 && last_n >= want_last) || (want_dat > 0 && dat_n >= want_dat);
      end
      if (want_last > 0 || want_dat > 0)
         check({tag, "_done"}, 72'(done), 72'(1));
   endtask

   task automatic open_path(input logic [31:0] ip, input logic [15:0] port);
      event_ip_i = ip; event_port_i = port; event_open_i = 1'b1;
      @(posedge aclk); #1;
      event_open_i = 1'b0; event_ip_i = '0; event_port_i = '0;
      @(posedge aclk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] exp_len [4];
      logic [63:0] exp_tag [4];
      cyc = 0; cur_ch = 0; hold = 0; bp = 0;
      areset = 1'b1;
      nfragment_count_i = 10'd7; fragsrc_mask_i = '0;
      event_open_i = 1'b0; event_ip_i = '0; event_port_i = '0;
      s_ctrl_tdata = '0; s_ctrl_tvalid = '1;
      s_data_tkeep = {kp(1), kp(0)}; s_data_tvalid = '1;
      m_hdr_tready = 1'b1; m_payload_tready = 1'b1;
      clear_logs();
      repeat (3) @(posedge aclk);
      #1;
      check("rst_ctrl_rdy", 72'(s_ctrl_tready), 72'(0));
      check("rst_data_rdy", 72'(s_data_tready), 72'(0));
      check("rst_hdr_vld", 72'(m_hdr_tvalid), 72'(0));
      check("rst_pay_vld", 72'(m_payload_tvalid), 72'(0));
      check("rst_tlast", 72'(m_payload_tlast), 72'(0));
      check("rst_drop", 72'(drop_count_o), 72'(0));
      s_ctrl_tvalid = '0;
      @(negedge aclk); areset = 1'b0;
      @(posedge aclk); #1;

      // Path never opened: 24 bytes drained as 3 beats, one drop.
      clear_logs();
      send(0, 12'h011, 20'd24);
      run("drain", 30, 0, 0);
      check("drain_grants", 72'(grant_q.size()), 72'(1));
      check("drain_beats", 72'(consumed[0]), 72'(3));
      check("drain_no_out", 72'(any_out), 72'(0));
      check("drain_drop", 72'(drop_count_o), 72'(1));

      // 200 bytes, nfrag 7, with output backpressure.
      open_path(32'hC0A8_0101, 16'h1234);
      clear_logs();
      fragsrc_mask_i = 16'h00FF; bp = 1;
      send(0, 12'hABC, 20'd200);
      run("p200", 600, 1, 0);
      bp = 0; m_hdr_tready = 1'b1; m_payload_tready = 1'b1;
      exp_len = '{16'd72, 16'd72, 16'd72, 16'd16};
      exp_tag = '{64'hDA7A_0000_ABC0_00C8, 64'hDA7A_0001_ABC0_00C8,
                  64'hDA7A_0002_ABC0_00C8, 64'hDA7A_0003_ABC0_00C8};
      check("p200_nhdr", 72'(hlen_q.size()), 72'(4));
      check("p200_ntag", 72'(tag_q.size()), 72'(4));
      for (int k = 0; k < 4; k++) begin
         check($sformatf("p200_len%0d", k), 72'(hlen_q[k]), 72'(exp_len[k]));
         check($sformatf("p200_tuser%0d", k), 72'(tuser_q[k]), 72'(16'h5400 + 16'(k)));
         check($sformatf("p200_tag%0d", k), 72'(tag_q[k]), 72'(exp_tag[k]));
      end
      check("p200_path", 72'(hpath_q[0]), 72'({32'hC0A8_0101, 16'h1234}));
      check("p200_beats", 72'(dat_n), 72'(25));
      check("p200_nlast", 72'(last_n), 72'(1));
      check("p200_last_at", 72'(last_at), 72'(25));
      check("p200_drop", 72'(drop_count_o), 72'(1));

      // 64 bytes on channel 1: single fragment of exactly 8 beats.
      clear_logs();
      fragsrc_mask_i = 16'h0000;
      send(1, 12'h123, 20'd64);
      run("p64", 100, 1, 0);
      check("p64_grant", 72'(grant_q[0]), 72'(1));
      check("p64_nhdr", 72'(hlen_q.size()), 72'(1));
      check("p64_len", 72'(hlen_q[0]), 72'(72));
      check("p64_tuser", 72'(tuser_q[0]), 72'(16'h5430));
      check("p64_tag", 72'(tag_q[0]), 72'(64'hDA7A_2000_1230_0040));
      check("p64_last_at", 72'(last_at), 72'(8));

      // Zero length: header length 8, tag beat carries tlast.
      clear_logs();
      send(0, 12'h055, 20'd0);
      run("p0", 50, 1, 0);
      check("p0_len", 72'(hlen_q[0]), 72'(8));
      check("p0_tag", 72'(tag_q[0]), 72'(64'hDA7A_0000_0550_0000));
      check("p0_beats", 72'(dat_n), 72'(0));
      check("p0_last_at", 72'(last_at), 72'(0));

      // nfrag 1: 17 bytes needs 3 beats (two fragments), 16 bytes fits in one.
      nfragment_count_i = 10'd1; fragsrc_mask_i = 16'hFFFF;
      clear_logs();
      send(0, 12'h7FF, 20'd17);
      run("p17", 100, 1, 0);
      check("p17_nhdr", 72'(hlen_q.size()), 72'(2));
      check("p17_len0", 72'(hlen_q[0]), 72'(24));
      check("p17_len1", 72'(hlen_q[1]), 72'(9));
      check("p17_tuser1", 72'(tuser_q[1]), 72'(16'h0001));
      check("p17_tag1", 72'(tag_q[1]), 72'(64'hDA7A_0001_7FF0_0011));
      check("p17_last_at", 72'(last_at), 72'(3));
      clear_logs();
      send(1, 12'h001, 20'd16);
      run("p16", 100, 1, 0);
      check("p16_nhdr", 72'(hlen_q.size()), 72'(1));
      check("p16_len", 72'(hlen_q[0]), 72'(24));
      check("p16_tag", 72'(tag_q[0]), 72'(64'hDA7A_2000_0010_0010));
      check("p16_last_at", 72'(last_at), 72'(2));

      // Both channels requesting continuously: grants alternate 0,1,0,1.
      nfragment_count_i = 10'd7;
      clear_logs();
      hold = 1;
      send(0, 12'h111, 20'd0);
      send(1, 12'h222, 20'd0);
      run("alt", 100, 4, 0);
      hold = 0; s_ctrl_tvalid = '0;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("alt_grant%0d", k), 72'(grant_q[k]), 72'(k % 2));
         check($sformatf("alt_tag%0d", k), 72'(tag_q[k]),
               72'((k % 2 == 0) ? 64'hDA7A_0000_1110_0000 : 64'hDA7A_2000_2220_0000));
      end

      // Reset in the middle of a stream, then a fresh packet.
      clear_logs();
      send(0, 12'h321, 20'd200);
      run("pre_rst", 200, 0, 5);
      check("pre_rst_vld", 72'(m_payload_tvalid), 72'(1));
      #2 areset = 1'b1;
      #1;
      check("mid_rst_pay_vld", 72'(m_payload_tvalid), 72'(0));
      check("mid_rst_hdr_vld", 72'(m_hdr_tvalid), 72'(0));
      check("mid_rst_data_rdy", 72'(s_data_tready), 72'(0));
      check("mid_rst_tlast", 72'(m_payload_tlast), 72'(0));
      check("mid_rst_drop", 72'(drop_count_o), 72'(0));
      repeat (2) @(posedge aclk);
      @(negedge aclk); areset = 1'b0;
      @(posedge aclk); #1;
      open_path(32'h0A00_0001, 16'h4321);
      clear_logs();
      send(0, 12'h456, 20'd64);
      run("post_rst", 100, 1, 0);
      check("post_rst_nhdr", 72'(hlen_q.size()), 72'(1));
      check("post_rst_len", 72'(hlen_q[0]), 72'(72));
      check("post_rst_path", 72'(hpath_q[0]), 72'({32'h0A00_0001, 16'h4321}));
      check("post_rst_tag", 72'(tag_q[0]), 72'(64'hDA7A_0000_4560_0040));
      check("post_rst_last_at", 72'(last_at), 72'(8));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
